// File: rtl/ahb_pkg.sv
// Shared AHB encodings and the slave FSM state type.
// Imported by every AHB block in this slice.
package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } slv_state_t;
endpackage

// File: rtl/ahb_slave_mem_if.sv
// AHB slave-side bus bundle; master drives address/control/wdata, slave returns ready/resp/rdata.
interface ahb_slave_mem_if;
  logic        hsel_i;
  logic [31:0] haddr_i;
  logic [1:0]  htrans_i;
  logic        hwrite_i;
  logic [2:0]  hsize_i;
  logic [31:0] hwdata_i;
  logic        hready_i;
  logic        hreadyout_o;
  logic [1:0]  hresp_o;
  logic [31:0] hrdata_o;

  modport slave (
    input  hsel_i, haddr_i, htrans_i, hwrite_i, hsize_i, hwdata_i, hready_i,
    output hreadyout_o, hresp_o, hrdata_o
  );

  modport master (
    output hsel_i, haddr_i, htrans_i, hwrite_i, hsize_i, hwdata_i, hready_i,
    input  hreadyout_o, hresp_o, hrdata_o
  );
endinterface

// File: rtl/ahb_slave_ram.sv
// DEPTH x 32 flop storage: one synchronous write port, one combinational read port.
// Every word clears to zero while reset is held.
module ahb_slave_ram #(
  parameter int DEPTH = 128
) (
  input  logic                     hclk_i,
  input  logic                     irst_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [31:0]              wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [31:0]              rdata
);
  logic [31:0] mem [DEPTH];

  always_ff @(posedge hclk_i) begin
    if (!irst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/ahb_slave_mem.sv
// Word-addressed AHB slave over flop storage: WAIT_CYCLES low cycles per OKAY beat,
// two-cycle ERROR for bad address/size, pipelined accept, registered read data with RAW forwarding.
module ahb_slave_mem
  import ahb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1A00,
  parameter int          DEPTH       = 128,
  parameter int          WAIT_CYCLES = 1
) (
  input logic            hclk_i,
  input logic            irst_n,
  ahb_slave_mem_if.slave bus
);
  localparam int          AW       = $clog2(DEPTH);
  localparam logic [31:0] END_ADDR = BASE_ADDR + 32'(4 * DEPTH);
  localparam logic [1:0]  WAIT_LD  = (WAIT_CYCLES > 0) ? 2'(WAIT_CYCLES - 1) : 2'd0;

  slv_state_t    state, state_nxt;
  logic [1:0]    wcnt, wcnt_nxt;
  logic [AW-1:0] idx_q, acc_idx, rd_idx;
  logic          write_q;
  logic [31:0]   rdata_q, ram_rdata, off;
  logic          accept, acc_err, take, commit, load_rd, rd_fwd;

  assign accept = bus.hsel_i && bus.hready_i &&
                  (bus.htrans_i == HTRANS_NONSEQ || bus.htrans_i == HTRANS_SEQ);
  assign off     = bus.haddr_i - BASE_ADDR;
  assign acc_idx = AW'(off >> 2);
  assign acc_err = (bus.haddr_i < BASE_ADDR) || (bus.haddr_i >= END_ADDR) ||
                   (bus.haddr_i[1:0] != 2'b00) || (bus.hsize_i != HSIZE_WORD);

  // Writes commit on the closing edge of DATA; errored transfers never reach DATA.
  assign commit = (state == S_DATA) && write_q;

  always_comb begin
    state_nxt        = state;
    wcnt_nxt         = wcnt;
    take             = 1'b0;
    bus.hreadyout_o  = 1'b1;
    bus.hresp_o      = HRESP_OKAY;
    case (state)
      S_WAIT: begin
        bus.hreadyout_o = 1'b0;
        if (wcnt == 2'd0) state_nxt = S_DATA;
        else              wcnt_nxt  = wcnt - 2'd1;
      end
      S_ERR1: begin
        bus.hreadyout_o = 1'b0;
        bus.hresp_o     = HRESP_ERROR;
        state_nxt       = S_ERR2;
      end
      default: begin
        if (state == S_ERR2) bus.hresp_o = HRESP_ERROR;
        take      = accept;
        state_nxt = S_IDLE;
        if (accept) begin
          if (acc_err) begin
            state_nxt = S_ERR1;
          end else if (WAIT_CYCLES > 0) begin
            state_nxt = S_WAIT;
            wcnt_nxt  = WAIT_LD;
          end else begin
            state_nxt = S_DATA;
          end
        end
      end
    endcase
  end

  // Read data is captured on the edge that enters DATA, from the new or the held address.
  assign rd_idx  = take ? acc_idx : idx_q;
  assign load_rd = (state_nxt == S_DATA) && !(take ? bus.hwrite_i : write_q);
  assign rd_fwd  = commit && (idx_q == rd_idx);

  always_ff @(posedge hclk_i) begin
    if (!irst_n) begin
      state   <= S_IDLE;
      wcnt    <= '0;
      idx_q   <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      if (take) begin
        idx_q   <= acc_idx;
        write_q <= bus.hwrite_i;
      end
      if (load_rd) rdata_q <= rd_fwd ? bus.hwdata_i : ram_rdata;
    end
  end

  assign bus.hrdata_o = rdata_q;

  ahb_slave_ram #(.DEPTH(DEPTH)) u_ram (
    .hclk_i (hclk_i),
    .irst_n (irst_n),
    .we     (commit),
    .waddr  (idx_q),
    .wdata  (bus.hwdata_i),
    .raddr  (rd_idx),
    .rdata  (ram_rdata)
  );
endmodule

// File: doc/ahb_slave_mem.md
# ahb_slave_mem

Word-addressed AHB slave with on-chip register-file storage, programmable wait states and ERROR responses. It is the responder for the team's burst master: it serves its INCR4 read bursts from the 0x1A00 region and absorbs its INCR4 write bursts to the 0x1B00 region. It sits behind the address decoder on the same hclk_i domain and can serve as the simulation target for master verification.

## Interface
- BASE_ADDR, 32'h1A00: byte address of word 0.
- DEPTH, 128: number of 32-bit words. The default window is 0x1A00–0x1BFF.
- WAIT_CYCLES, 1: number of hreadyout_o-low cycles per OKAY data phase. Legal range is 0..3.
- hclk_i  input  1  clock.
- irst_n  input  1  reset, synchronous, active-low.
- hsel_i  input  1  slave select from the decoder.
- haddr_i  input  32  byte address.
- htrans_i  input  2  transfer type: IDLE 00, BUSY 01, NONSEQ 10, SEQ 11.
- hwrite_i  input  1  1 = write, 0 = read.
- hsize_i  input  3  transfer size. Only 3'b010 (word) is legal.
- hwdata_i  input  32  write data, valid in the data phase.
- hready_i  input  1  bus-level ready, i.e. the previous transfer has completed.
- hreadyout_o  output  1  slave ready. Resets to 1.
- hresp_o  output  2  response: OKAY 00, ERROR 01. Resets to 00.
- hrdata_o  output  32  read data. Resets to 0.

## Operation
- **Address-phase accept.** An address phase is accepted on a rising edge when hsel_i & hready_i & htrans_i[1] are all 1. At accept, the block latches addr, write, size and an error flag.
- **Ignored phases.** If hsel_i is 0, or htrans_i is IDLE or BUSY, there is no accept. The following cycle is a zero-wait OKAY with no storage access.
- **Error flag.** The error flag is set for any of:
  - haddr_i < BASE_ADDR;
  - haddr_i ≥ BASE_ADDR + 4*DEPTH;
  - haddr_i[1:0] ≠ 0;
  - hsize_i ≠ 3'b010.
- **Word index.** (haddr_i − BASE_ADDR) >> 2, width $clog2(DEPTH).
- **FSM states.** IDLE, WAIT, DATA, ERR1, ERR2.
- **From IDLE** (also taken from the completing DATA or ERR2 cycle):
  - accepted and error → ERR1;
  - accepted and WAIT_CYCLES > 0 → WAIT, with the wait counter loaded to WAIT_CYCLES−1;
  - accepted and WAIT_CYCLES = 0 → DATA;
  - otherwise → IDLE.
- **WAIT.** hreadyout_o = 0 and hresp_o = OKAY. The counter decrements each cycle. When it reaches 0 the FSM goes to DATA.
- **DATA.** hreadyout_o = 1 and hresp_o = OKAY.
  - Write: mem[idx] <= hwdata_i on the closing edge.
  - Read: hrdata_o holds mem[idx].
  - The next address is accepted on the same closing edge (pipelined).
- **ERR1.** hreadyout_o = 0, hresp_o = ERROR, then the FSM goes to ERR2.
- **ERR2.** hreadyout_o = 1, hresp_o = ERROR. A pipelined next address is accepted normally.
- Storage is never written on an ERROR transfer.
- **Read data.** hrdata_o is registered. It loads mem[idx] on the edge entering DATA and holds its value outside read data phases.
- **Read-after-write forwarding.** The case is a read accepted on the same edge that commits a write to the same index. In that case hrdata_o takes hwdata_i, not the stale storage value.
- **Reset.** irst_n low at any time forces:
  - FSM to IDLE, wait counter to 0, outputs to their reset values;
  - all storage words to 0.
  
  Any in-flight write is dropped.

## Timing
- Accept at edge N:
  - hreadyout_o is low during cycles N+1 .. N+WAIT_CYCLES;
  - the completing cycle is N+WAIT_CYCLES+1.
- With WAIT_CYCLES = 0, an INCR4 burst completes in 5 cycles (address + 4 data, fully pipelined). With WAIT_CYCLES = 1 it takes 9 cycles.
- An ERROR response always takes exactly 2 cycles, independent of WAIT_CYCLES.
- hrdata_o is valid throughout the DATA cycle of a read. It is guaranteed only when hreadyout_o = 1.
- Write data is sampled only on the closing edge of DATA. hwdata_i is ignored during WAIT.
- hready_i low with hsel_i high: no accept, and the FSM state is unaffected.

## Structure
- Shared package ahb_pkg holds:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ;
  - HRESP_OKAY/ERROR;
  - HSIZE_WORD;
  - the slave FSM state enum.
- Sub-module ahb_slave_ram contains:
  - DEPTH x 32 flops with a synchronous reset-to-zero;
  - one write port (we, waddr, wdata);
  - one combinational read port.
- The top level contains the FSM, address-phase registers, decode/error logic, wait counter and forwarding mux.

## Test plan
- Reset with htrans_i = IDLE → hreadyout_o = 1, hresp_o = 00, hrdata_o = 0. Then read 0x1A00 → 0x00000000 OKAY.
- WAIT_CYCLES = 1: INCR4 write of 0x11, 0x22, 0x33, 0x44 to 0x1B00–0x1B0C, then INCR4 read of 0x1B00–0x1B0C.
  - Each beat shows 1 low cycle then 1 high cycle.
  - The read returns 0x11, 0x22, 0x33, 0x44.
- WAIT_CYCLES = 0: write 0xA5A5A5A5 to 0x1A04, immediately followed by a read of 0x1A04 → hrdata_o = 0xA5A5A5A5 with no wait (forwarding).
- NONSEQ write to 0x1C00, then to 0x1A02, then with hsize_i = 000 → each gives ERROR (low+ERROR, high+ERROR). A following read shows the target words are still 0, with OKAY.
- Assert irst_n low during the WAIT cycle of a write of 0xDEADBEEF to 0x1A10 → outputs return to reset values. A later read of 0x1A10 returns 0.
- NONSEQ with hsel_i = 0, and BUSY with hsel_i = 1 → next cycle hreadyout_o = 1, OKAY, storage unchanged.
